// File: rtl/mesi_types.sv
// -----------------------------------------------------------------------------
// mesi_types
// Shared type definitions for the MESI snoop bus.
//   bus_request : command a cache controller places on the snoop bus.
//                 No_OP means "no request".
// -----------------------------------------------------------------------------
package mesi_types;

    typedef enum logic [2:0] {
        No_OP   = 3'd0,
        BusRd   = 3'd1,
        BusRdX  = 3'd2,
        BusUpgr = 3'd3,
        Flush   = 3'd4
    } bus_request;

endpackage : mesi_types

// File: rtl/snoop_bus_arbiter.sv
// -----------------------------------------------------------------------------
// snoop_bus_arbiter
// Round-robin arbiter and transaction sequencer for the shared MESI snoop bus.
// One cache owns the bus at a time. The winner's command and address are
// broadcast to all snoopers, and ownership is held until bus_done.
//
// Optional feature (compile-time macro SNOOP_ARB_TIMEOUT_EN):
//   WAIT-state watchdog. After TIMEOUT_CYCLES WAIT cycles without bus_done,
//   the transaction is aborted and timeout_err pulses. Without the macro,
//   WAIT holds indefinitely and timeout_err is always 0.
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   req_cmd     in   per-cache bus request (No_OP = idle)
//   req_addr    in   per-cache request address
//   bus_done    in   current transaction finished
//   cmd_out     out  broadcast command
//   addr_out    out  broadcast address
//   bus_owner   out  one-hot owner, all zero = bus idle
//   bcast_valid out  one-cycle pulse marking a new broadcast
//   busy        out  high while a transaction is in flight
//   timeout_err out  one-cycle pulse on watchdog abort
// -----------------------------------------------------------------------------
module snoop_bus_arbiter
    import mesi_types::*;
#(
    parameter int N_CACHES       = 2,
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  bus_request                       req_cmd [N_CACHES],
    input  logic [N_CACHES-1:0][ADDR_W-1:0]  req_addr,
    input  logic                             bus_done,
    output bus_request                       cmd_out,
    output logic [ADDR_W-1:0]                addr_out,
    output logic [N_CACHES-1:0]              bus_owner,
    output logic                             bcast_valid,
    output logic                             busy,
    output logic                             timeout_err
);

    localparam int IDX_W = $clog2(N_CACHES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BCAST = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Reject unsupported configurations at elaboration time.
    if ((N_CACHES < 2) || (N_CACHES > 8) || (TIMEOUT_CYCLES < 1)) begin : g_bad_param
        $error("snoop_bus_arbiter: N_CACHES must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    state_t             state_r;
    logic [IDX_W-1:0]   last_owner_r;
    logic [IDX_W-1:0]   grant_idx_r;
    logic               found_s;
    logic [IDX_W-1:0]   win_idx_s;

`ifdef SNOOP_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]   wait_cnt_r;
`endif

    // Round-robin pick: scan upward from last_owner+1 with wrap, so the
    // previous owner is examined last and gets the lowest priority.
    always_comb begin
        found_s   = 1'b0;
        win_idx_s = {IDX_W{1'b0}};
        for (int k = 1; k <= N_CACHES; k++) begin
            if (!found_s && (req_cmd[IDX_W'((int'(last_owner_r) + k) % N_CACHES)] != No_OP)) begin
                found_s   = 1'b1;
                win_idx_s = IDX_W'((int'(last_owner_r) + k) % N_CACHES);
            end else begin
                found_s   = found_s;
            end
        end
    end

    // Sequencer FSM with registered broadcast outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            last_owner_r <= IDX_W'(N_CACHES - 1);
            grant_idx_r  <= {IDX_W{1'b0}};
            cmd_out      <= No_OP;
            addr_out     <= {ADDR_W{1'b0}};
            bus_owner    <= {N_CACHES{1'b0}};
            bcast_valid  <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
`ifdef SNOOP_ARB_TIMEOUT_EN
            wait_cnt_r   <= {CNT_W{1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    timeout_err <= 1'b0;
                    if (found_s) begin
                        cmd_out     <= req_cmd[win_idx_s];
                        addr_out    <= req_addr[win_idx_s];
                        bus_owner   <= {{(N_CACHES-1){1'b0}}, 1'b1} << win_idx_s;
                        grant_idx_r <= win_idx_s;
                        bcast_valid <= 1'b1;
                        busy        <= 1'b1;
                        state_r     <= BCAST;
                    end else begin
                        cmd_out     <= No_OP;
                        addr_out    <= {ADDR_W{1'b0}};
                        bus_owner   <= {N_CACHES{1'b0}};
                        bcast_valid <= 1'b0;
                        busy        <= 1'b0;
                    end
                end
                // Single broadcast cycle; bus_done is deliberately not looked at.
                BCAST: begin
                    bcast_valid <= 1'b0;
                    state_r     <= WAIT;
`ifdef SNOOP_ARB_TIMEOUT_EN
                    wait_cnt_r  <= {CNT_W{1'b0}};
`endif
                end
                WAIT: begin
                    // bus_done has priority over a watchdog expiry in the same cycle.
                    if (bus_done) begin
                        cmd_out      <= No_OP;
                        addr_out     <= {ADDR_W{1'b0}};
                        bus_owner    <= {N_CACHES{1'b0}};
                        busy         <= 1'b0;
                        last_owner_r <= grant_idx_r;
                        state_r      <= IDLE;
`ifdef SNOOP_ARB_TIMEOUT_EN
                    end else if (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        cmd_out      <= No_OP;
                        addr_out     <= {ADDR_W{1'b0}};
                        bus_owner    <= {N_CACHES{1'b0}};
                        busy         <= 1'b0;
                        timeout_err  <= 1'b1;
                        last_owner_r <= grant_idx_r;
                        state_r      <= IDLE;
                    end else begin
                        wait_cnt_r   <= wait_cnt_r + CNT_W'(1'b1);
                    end
`else
                    end else begin
                        state_r      <= WAIT;
                    end
`endif
                end
                default: begin
                    state_r     <= IDLE;
                    cmd_out     <= No_OP;
                    addr_out    <= {ADDR_W{1'b0}};
                    bus_owner   <= {N_CACHES{1'b0}};
                    bcast_valid <= 1'b0;
                    busy        <= 1'b0;
                    timeout_err <= 1'b0;
                end
            endcase
        end
    end

endmodule : snoop_bus_arbiter

// File: tb/tb_snoop_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_snoop_bus_arbiter
// Directed bench for snoop_bus_arbiter: a 2-cache instance and a 4-cache
// instance. Expected grants are queued by the stimulus; monitors pop and
// compare whenever bcast_valid is seen.
// -----------------------------------------------------------------------------
module tb_snoop_bus_arbiter;
    import mesi_types::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 2-cache instance
    bus_request       req_cmd [2];
    logic [1:0][7:0]  req_addr;
    logic             bus_done;
    bus_request       cmd_out;
    logic [7:0]       addr_out;
    logic [1:0]       bus_owner;
    logic             bcast_valid, busy, timeout_err;

    // 4-cache instance
    bus_request       req_cmd4 [4];
    logic [3:0][7:0]  req_addr4;
    logic             bus_done4;
    bus_request       cmd_out4;
    logic [7:0]       addr_out4;
    logic [3:0]       bus_owner4;
    logic             bcast_valid4, busy4, timeout_err4;

    snoop_bus_arbiter #(.N_CACHES(2), .ADDR_W(8), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .req_cmd(req_cmd), .req_addr(req_addr),
        .bus_done(bus_done), .cmd_out(cmd_out), .addr_out(addr_out),
        .bus_owner(bus_owner), .bcast_valid(bcast_valid), .busy(busy),
        .timeout_err(timeout_err)
    );

    snoop_bus_arbiter #(.N_CACHES(4), .ADDR_W(8), .TIMEOUT_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .req_cmd(req_cmd4), .req_addr(req_addr4),
        .bus_done(bus_done4), .cmd_out(cmd_out4), .addr_out(addr_out4),
        .bus_owner(bus_owner4), .bcast_valid(bcast_valid4), .busy(busy4),
        .timeout_err(timeout_err4)
    );

    typedef struct {
        logic [1:0] owner;
        bus_request cmd;
        logic [7:0] addr;
    } exp2_t;

    typedef struct {
        logic [3:0] owner;
        bus_request cmd;
        logic [7:0] addr;
    } exp4_t;

    exp2_t exp2_q[$];
    exp4_t exp4_q[$];
    exp2_t mon2_e;
    exp4_t mon4_e;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push2(input logic [1:0] owner, input bus_request cmd, input logic [7:0] addr);
        exp2_t e;
        e.owner = owner; e.cmd = cmd; e.addr = addr;
        exp2_q.push_back(e);
    endtask

    task automatic push4(input logic [3:0] owner, input bus_request cmd, input logic [7:0] addr);
        exp4_t e;
        e.owner = owner; e.cmd = cmd; e.addr = addr;
        exp4_q.push_back(e);
    endtask

    task automatic chk_idle2(input string name);
        chk({name, "_owner"}, 32'(bus_owner), 32'h0);
        chk({name, "_cmd"},   32'(cmd_out),   32'(No_OP));
        chk({name, "_addr"},  32'(addr_out),  32'h0);
        chk({name, "_busy"},  32'(busy),      32'h0);
    endtask

    // Monitor for the 2-cache instance: every broadcast must match the next queued grant.
    always @(negedge clk) begin
        if (bcast_valid === 1'b1) begin
            if (exp2_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL grant2_unexpected: got owner=%b expected no broadcast", bus_owner);
            end else begin
                mon2_e = exp2_q.pop_front();
                chk("grant2_owner", 32'(bus_owner), 32'(mon2_e.owner));
                chk("grant2_cmd",   32'(cmd_out),   32'(mon2_e.cmd));
                chk("grant2_addr",  32'(addr_out),  32'(mon2_e.addr));
                chk("grant2_busy",  32'(busy),      32'h1);
            end
        end
    end

    // Monitor for the 4-cache instance.
    always @(negedge clk) begin
        if (bcast_valid4 === 1'b1) begin
            if (exp4_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL grant4_unexpected: got owner=%b expected no broadcast", bus_owner4);
            end else begin
                mon4_e = exp4_q.pop_front();
                chk("grant4_owner", 32'(bus_owner4), 32'(mon4_e.owner));
                chk("grant4_cmd",   32'(cmd_out4),   32'(mon4_e.cmd));
                chk("grant4_addr",  32'(addr_out4),  32'(mon4_e.addr));
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus_done = 1'b0;
        bus_done4 = 1'b0;
        req_cmd[0] = No_OP; req_cmd[1] = No_OP;
        req_addr = '0;
        for (int i = 0; i < 4; i++) req_cmd4[i] = No_OP;
        req_addr4 = '0;

        // Reset values
        repeat (2) tick();
        chk_idle2("reset");
        chk("reset_bcast",   32'(bcast_valid), 32'h0);
        chk("reset_timeout", 32'(timeout_err), 32'h0);
        rst = 1'b0;

        // Single request from cache0
        req_cmd[0] = BusRd; req_addr[0] = 8'h3C;
        push2(2'b01, BusRd, 8'h3C);
        tick();                                   // grant edge
        chk("t1_owner_at_grant", 32'(bus_owner), 32'h1);
        req_cmd[0] = No_OP;
        tick();                                   // WAIT
        chk("t1_bcast_one_cycle", 32'(bcast_valid), 32'h0);
        chk("t1_owner_wait", 32'(bus_owner), 32'h1);
        chk("t1_busy_wait",  32'(busy), 32'h1);
        tick();
        bus_done = 1'b1;
        tick();                                   // completion edge
        bus_done = 1'b0;
        chk_idle2("t1_done");

        // Both caches continuously: 01,10,01,10 with an idle gap
        rst = 1'b1; tick(); rst = 1'b0;
        req_cmd[0] = BusRdX; req_addr[0] = 8'hA0;
        req_cmd[1] = BusRdX; req_addr[1] = 8'hA1;
        for (int i = 0; i < 4; i++) begin
            push2((i % 2 == 0) ? 2'b01 : 2'b10, BusRdX, (i % 2 == 0) ? 8'hA0 : 8'hA1);
            tick();                               // grant
            tick();                               // WAIT
            bus_done = 1'b1;
            tick();                               // completion -> IDLE
            bus_done = 1'b0;
            chk("t2_idle_gap_owner", 32'(bus_owner), 32'h0);
        end
        req_cmd[0] = No_OP; req_cmd[1] = No_OP;

        // Cache1 drops request during WAIT; bus_done during BCAST ignored
        req_cmd[1] = BusUpgr; req_addr[1] = 8'h80;
        push2(2'b10, BusUpgr, 8'h80);
        tick();                                   // grant, BCAST next
        bus_done = 1'b1;
        tick();                                   // BCAST -> WAIT, done ignored
        bus_done = 1'b0;
        req_cmd[1] = No_OP; req_addr[1] = 8'h11;
        chk("t3_done_in_bcast_ignored", 32'(bus_owner), 32'h2);
        tick(); tick();
        chk("t3_hold_owner", 32'(bus_owner), 32'h2);
        chk("t3_hold_addr",  32'(addr_out),  32'h80);
        chk("t3_hold_cmd",   32'(cmd_out),   32'(BusUpgr));
        bus_done = 1'b1;
        tick();
        bus_done = 1'b0;
        chk_idle2("t3_done");
        bus_done = 1'b1;                          // bus_done in IDLE
        tick();
        bus_done = 1'b0;
        chk("t3_idle_done_busy",  32'(busy), 32'h0);
        chk("t3_idle_done_bcast", 32'(bcast_valid), 32'h0);

        // Async reset mid-WAIT, then cache0 wins first
        req_cmd[1] = BusRd; req_addr[1] = 8'h55;
        push2(2'b10, BusRd, 8'h55);
        tick(); tick();                           // WAIT
        req_cmd[1] = No_OP;
        #2 rst = 1'b1;
        #1;
        chk_idle2("t4_async_rst");
        chk("t4_async_rst_bcast", 32'(bcast_valid), 32'h0);
        tick();
        rst = 1'b0;
        req_cmd[0] = BusRd;  req_addr[0] = 8'h10;
        req_cmd[1] = BusRdX; req_addr[1] = 8'h20;
        push2(2'b01, BusRd, 8'h10);
        tick();
        req_cmd[0] = No_OP;
        chk("t4_first_after_rst", 32'(bus_owner), 32'h1);
        tick();
        bus_done = 1'b1;
        tick();
        bus_done = 1'b0;
        push2(2'b10, BusRdX, 8'h20);              // pending cache1
        tick();
        req_cmd[1] = No_OP;
        tick();
        bus_done = 1'b1;
        tick();
        bus_done = 1'b0;

`ifdef SNOOP_ARB_TIMEOUT_EN
        // Watchdog abort after 4 WAIT cycles, pending cache1 served next
        req_cmd[0] = Flush; req_addr[0] = 8'h0F;
        push2(2'b01, Flush, 8'h0F);
        tick();                                   // g
        req_cmd[0] = No_OP;
        req_cmd[1] = BusRd; req_addr[1] = 8'h33;
        tick(); tick(); tick(); tick();           // g+1..g+4
        chk("t5_no_timeout_yet", 32'(timeout_err), 32'h0);
        chk("t5_owner_before_to", 32'(bus_owner), 32'h1);
        push2(2'b10, BusRd, 8'h33);
        tick();                                   // g+5 abort
        chk("t5_timeout_pulse", 32'(timeout_err), 32'h1);
        chk_idle2("t5_after_timeout");
        tick();                                   // grant cache1
        chk("t5_timeout_one_cycle", 32'(timeout_err), 32'h0);
        req_cmd[1] = No_OP;
        tick();                                   // WAIT entry
        tick(); tick(); tick();
        bus_done = 1'b1;
        tick();                                   // expiry edge, done wins
        bus_done = 1'b0;
        chk("t5_done_wins_no_err", 32'(timeout_err), 32'h0);
        chk_idle2("t5_done_wins");
        tick();
        chk("t5_done_wins_no_err_later", 32'(timeout_err), 32'h0);
`else
        // No watchdog: WAIT holds indefinitely
        req_cmd[0] = Flush; req_addr[0] = 8'h0F;
        push2(2'b01, Flush, 8'h0F);
        tick();
        req_cmd[0] = No_OP;
        tick();
        repeat (10) tick();
        chk("t5_hold_owner", 32'(bus_owner), 32'h1);
        chk("t5_hold_busy",  32'(busy), 32'h1);
        chk("t5_no_timeout", 32'(timeout_err), 32'h0);
        bus_done = 1'b1;
        tick();
        bus_done = 1'b0;
        chk_idle2("t5_done");
`endif

        // 4-cache instance: set last_owner=1, then caches 1 and 3 -> 3 then 1
        req_cmd4[1] = BusRd; req_addr4[1] = 8'h41;
        push4(4'b0010, BusRd, 8'h41);
        tick();
        req_cmd4[1] = No_OP;
        tick();
        bus_done4 = 1'b1;
        tick();
        bus_done4 = 1'b0;
        req_cmd4[1] = BusRdX; req_addr4[1] = 8'h42;
        req_cmd4[3] = BusUpgr; req_addr4[3] = 8'h43;
        push4(4'b1000, BusUpgr, 8'h43);
        push4(4'b0010, BusRdX, 8'h42);
        tick();                                   // grant cache3
        chk("t6_first_is_3", 32'(bus_owner4), 32'h8);
        req_cmd4[3] = No_OP;
        tick();
        bus_done4 = 1'b1;
        tick();
        bus_done4 = 1'b0;
        tick();                                   // grant cache1
        chk("t6_second_is_1", 32'(bus_owner4), 32'h2);
        req_cmd4[1] = No_OP;
        tick();
        bus_done4 = 1'b1;
        tick();
        bus_done4 = 1'b0;
        chk("t6_idle_owner", 32'(bus_owner4), 32'h0);

        repeat (2) tick();
        chk("exp2_queue_drained", 32'(exp2_q.size()), 32'h0);
        chk("exp4_queue_drained", 32'(exp4_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_snoop_bus_arbiter
